// File: rtl/complex_alu_ctrl.sv
// Issue/writeback controller for the multi-cycle complex ALU: slot reservation at issue, in-order-of-completion writeback.
// Optional CALU_DIVZERO_TRAP_EN: div/mod by zero traps to wb_divz with a fixed result instead of the ALU output.
module complex_alu_ctrl #(
    parameter int TAG_W   = 5,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 12,
    parameter int SHF_LAT = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [31:0]      req_srcA,
    input  logic [31:0]      req_srcB,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic [31:0]      alu_srcA,
    output logic [31:0]      alu_srcB,
    output logic [2:0]       alu_op,
    output logic [2:0]       alu_select,
    input  logic [31:0]      alu_result,
    output logic             wb_valid,
    output logic [31:0]      wb_data,
    output logic [TAG_W-1:0] wb_tag,
    output logic             wb_illegal,
    output logic             wb_divz,
    output logic             busy
);

    function automatic logic [3:0] lat_of(input logic [2:0] op);
        case (op)
            3'd1:       lat_of = 4'(MUL_LAT);
            3'd2, 3'd3: lat_of = 4'(DIV_LAT);
            default:    lat_of = 4'(SHF_LAT);
        endcase
    endfunction

    function automatic logic is_illegal(input logic [2:0] op);
        is_illegal = (op == 3'd0) || (op > 3'd5);
    endfunction

    // Slot k retires k cycles from now; slot 1 is selected onto the ALU result mux.
    logic [15:1]             vld_q, vld_d;
    logic [15:1][2:0]        op_q, op_d;
    logic [15:1][TAG_W-1:0]  tag_q, tag_d;
    logic [16:1]             vld_ext;
    logic [3:0]              req_lat, ins_idx;
    logic [4:0]              chk_idx;
    logic                    fire, retire;
    logic [31:0]             ret_data;

    logic [31:0]             alu_srcA_q, alu_srcB_q;
    logic [2:0]              alu_op_q;
    logic                    wb_valid_q, wb_illegal_q;
    logic [31:0]             wb_data_q;
    logic [TAG_W-1:0]        wb_tag_q;

    assign req_lat = lat_of(req_op);
    assign ins_idx = req_lat + 4'd1;
    // The target slot is checked as it will look after this cycle's shift.
    assign chk_idx = {1'b0, req_lat} + 5'd2;
    assign vld_ext = {1'b0, vld_q};
    assign req_ready = !reset && !flush && !vld_ext[chk_idx];
    assign fire = req_valid && req_ready;
    assign retire = vld_q[1] && !flush;

    assign alu_select = vld_q[1] ? op_q[1] : 3'd0;
    assign busy = |vld_q;

`ifdef CALU_DIVZERO_TRAP_EN
    logic [15:1]        dz_q, dz_d;
    logic [15:1][31:0]  sa_q, sa_d;
    logic               wb_divz_q;

    always_comb begin
        dz_d = {1'b0, dz_q[15:2]};
        sa_d = {32'd0, sa_q[15:2]};
        if (fire) begin
            dz_d[ins_idx] = (req_op == 3'd2 || req_op == 3'd3) && (req_srcB == 32'd0);
            sa_d[ins_idx] = req_srcA;
        end
    end

    always_comb begin
        ret_data = alu_result;
        if (is_illegal(op_q[1]))
            ret_data = 32'd0;
        else if (dz_q[1])
            ret_data = (op_q[1] == 3'd2) ? 32'hFFFF_FFFF : sa_q[1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dz_q      <= '0;
            sa_q      <= '0;
            wb_divz_q <= 1'b0;
        end else begin
            dz_q      <= dz_d;
            sa_q      <= sa_d;
            wb_divz_q <= retire && dz_q[1] && !is_illegal(op_q[1]);
        end
    end

    assign wb_divz = wb_divz_q;
`else
    assign ret_data = is_illegal(op_q[1]) ? 32'd0 : alu_result;
    assign wb_divz  = 1'b0;
`endif

    always_comb begin
        vld_d = {1'b0, vld_q[15:2]};
        op_d  = {3'd0, op_q[15:2]};
        tag_d = {{TAG_W{1'b0}}, tag_q[15:2]};
        if (fire) begin
            vld_d[ins_idx] = 1'b1;
            op_d[ins_idx]  = req_op;
            tag_d[ins_idx] = req_tag;
        end
        if (flush)
            vld_d = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            vld_q        <= '0;
            op_q         <= '0;
            tag_q        <= '0;
            alu_srcA_q   <= '0;
            alu_srcB_q   <= '0;
            alu_op_q     <= '0;
            wb_valid_q   <= 1'b0;
            wb_data_q    <= '0;
            wb_tag_q     <= '0;
            wb_illegal_q <= 1'b0;
        end else begin
            vld_q        <= vld_d;
            op_q         <= op_d;
            tag_q        <= tag_d;
            // Idle cycles drive zeros so the ALU's operand gating stays quiet.
            alu_srcA_q   <= fire ? req_srcA : 32'd0;
            alu_srcB_q   <= fire ? req_srcB : 32'd0;
            alu_op_q     <= (fire && !is_illegal(req_op)) ? req_op : 3'd0;
            wb_valid_q   <= retire;
            wb_data_q    <= retire ? ret_data : 32'd0;
            wb_tag_q     <= retire ? tag_q[1] : '0;
            wb_illegal_q <= retire && is_illegal(op_q[1]);
        end
    end

    assign alu_srcA   = alu_srcA_q;
    assign alu_srcB   = alu_srcB_q;
    assign alu_op     = alu_op_q;
    assign wb_valid   = wb_valid_q;
    assign wb_data    = wb_data_q;
    assign wb_tag     = wb_tag_q;
    assign wb_illegal = wb_illegal_q;

endmodule

// File: tb/tb_complex_alu_ctrl.sv
// Scoreboard bench for complex_alu_ctrl: directed issue sequences, a latency-accurate ALU model, and a writeback monitor.
module tb_complex_alu_ctrl;
    localparam int TAG_W = 5;

    logic             clock = 1'b0;
    logic             reset, req_valid, req_ready, flush;
    logic [2:0]       req_op, alu_op, alu_select;
    logic [31:0]      req_srcA, req_srcB, alu_srcA, alu_srcB, alu_result, wb_data;
    logic [TAG_W-1:0] req_tag, wb_tag;
    logic             wb_valid, wb_illegal, wb_divz, busy;

    complex_alu_ctrl #(.TAG_W(TAG_W), .MUL_LAT(5), .DIV_LAT(12), .SHF_LAT(2)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_srcA(req_srcA), .req_srcB(req_srcB), .req_tag(req_tag),
        .flush(flush), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_op(alu_op),
        .alu_select(alu_select), .alu_result(alu_result), .wb_valid(wb_valid),
        .wb_data(wb_data), .wb_tag(wb_tag), .wb_illegal(wb_illegal), .wb_divz(wb_divz),
        .busy(busy)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int               due;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic             ill;
        logic             dz;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int due, input logic [TAG_W-1:0] tag, input logic [31:0] data,
                        input logic ill, input logic dz);
        exp_t e;
        e.due = due; e.tag = tag; e.data = data; e.ill = ill; e.dz = dz;
        sb.push_back(e);
    endtask

    // ALU model: a result selected in cycle c comes from the operands presented L(sel) cycles earlier.
    logic [2:0]  h_op [0:4095];
    logic [31:0] h_a  [0:4095];
    logic [31:0] h_b  [0:4095];

    function automatic int lat(input logic [2:0] op);
        case (op)
            3'd1:       lat = 5;
            3'd2, 3'd3: lat = 12;
            default:    lat = 2;
        endcase
    endfunction

    function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd1: alu_f = a * b;
            3'd2: alu_f = (b == 0) ? 32'h0000_1234 : a / b;
            3'd3: alu_f = (b == 0) ? 32'h0000_1234 : a % b;
            3'd4: alu_f = a << b[4:0];
            3'd5: alu_f = a >> b[4:0];
            default: alu_f = 32'hDEAD_BEEF;
        endcase
    endfunction

    initial alu_result = 32'd0;
    always @(negedge clock) begin
        logic [11:0] wi, pi;
        wi = 12'(cyc);
        h_op[wi] = alu_op; h_a[wi] = alu_srcA; h_b[wi] = alu_srcB;
        if (alu_select != 3'd0 && cyc >= lat(alu_select)) begin
            pi = 12'(cyc - lat(alu_select));
            alu_result = alu_f(h_op[pi], h_a[pi], h_b[pi]);
        end else begin
            alu_result = 32'd0;
        end
    end

    // Monitor: every writeback must match an expectation due this very cycle.
    always @(negedge clock) begin
        if (!reset) begin
            if (wb_valid) begin
                int idx;
                idx = -1;
                for (int i = 0; i < sb.size(); i++)
                    if (idx < 0 && sb[i].due == cyc) idx = i;
                if (idx < 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_wb: got tag %0d data %h at cycle %0d, expected no writeback",
                             wb_tag, wb_data, cyc);
                end else begin
                    chk("wb_tag", 32'(wb_tag), 32'(sb[idx].tag));
                    chk("wb_data", wb_data, sb[idx].data);
                    chk("wb_illegal", 32'(wb_illegal), 32'(sb[idx].ill));
                    chk("wb_divz", 32'(wb_divz), 32'(sb[idx].dz));
                    sb.delete(idx);
                end
            end
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due < cyc) begin
                    checks++; errors++;
                    $display("FAIL missing_wb: got nothing for tag %0d, expected at cycle %0d", sb[i].tag, sb[i].due);
                    sb.delete(i);
                end
            end
        end
    end

    task automatic step;
        @(posedge clock); #1;
    endtask

    task automatic mid;
        @(negedge clock);
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag);
        req_valid = 1'b1; req_op = op; req_srcA = a; req_srcB = b; req_tag = tag;
    endtask

    task automatic idle;
        req_valid = 1'b0; req_op = 3'd1; req_srcA = 32'd0; req_srcB = 32'd0; req_tag = '0;
    endtask

    int t;
    logic [31:0] exp_div0, exp_mod0;
    logic        exp_dz;

    initial begin
        reset = 1'b1; flush = 1'b0; idle();
        repeat (2) step();
        mid();
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        step(); reset = 1'b0;
        mid();
        chk("idle_ready", 32'(req_ready), 32'd1);

        // Single mul: 7*6 tag 3, result 7 cycles after fire, busy for 6.
        step(); drive(3'd1, 32'd7, 32'd6, 5'd3);
        mid(); chk("mul_ready", 32'(req_ready), 32'd1);
        t = cyc; push(t + 7, 5'd3, 32'd42, 1'b0, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            step(); if (i == 1) idle();
            mid();
            chk("mul_busy", 32'(busy), (i <= 6) ? 32'd1 : 32'd0);
            if (i == 1) begin
                chk("mul_alu_op", 32'(alu_op), 32'd1);
                chk("mul_alu_srcA", alu_srcA, 32'd7);
                chk("mul_alu_srcB", alu_srcB, 32'd6);
            end
            if (i == 2) chk("idle_alu_op", 32'(alu_op), 32'd0);
        end

        // Collision: shl offered 3 cycles after a mul stalls one cycle.
        step(); drive(3'd1, 32'd3, 32'd4, 5'd4);
        mid(); chk("col_mul_ready", 32'(req_ready), 32'd1);
        t = cyc; push(t + 7, 5'd4, 32'd12, 1'b0, 1'b0);
        step(); idle();
        step();
        step(); drive(3'd4, 32'd1, 32'd4, 5'd5);
        mid(); chk("col_shl_stall", 32'(req_ready), 32'd0);
        step();
        mid(); chk("col_shl_ready", 32'(req_ready), 32'd1);
        push(cyc + 4, 5'd5, 32'd16, 1'b0, 1'b0);
        step(); idle();
        repeat (6) step();

        // Out of order: long div then short shr.
        step(); drive(3'd2, 32'd100, 32'd7, 5'd1);
        mid(); chk("ooo_div_ready", 32'(req_ready), 32'd1);
        t = cyc; push(t + 14, 5'd1, 32'd14, 1'b0, 1'b0);
        step(); drive(3'd5, 32'h80, 32'd3, 5'd2);
        mid(); chk("ooo_shr_ready", 32'(req_ready), 32'd1);
        push(t + 5, 5'd2, 32'h10, 1'b0, 1'b0);
        step(); idle();
        repeat (14) step();

        // Back-to-back shr every cycle.
        step(); drive(3'd5, 32'hF0, 32'd4, 5'd10);
        mid(); chk("b2b_ready0", 32'(req_ready), 32'd1);
        t = cyc; push(t + 4, 5'd10, 32'h0F, 1'b0, 1'b0);
        step(); drive(3'd5, 32'h100, 32'd8, 5'd11);
        mid(); chk("b2b_ready1", 32'(req_ready), 32'd1);
        push(t + 5, 5'd11, 32'd1, 1'b0, 1'b0);
        step(); idle();
        repeat (6) step();

        // Flush with three muls in flight; a request offered during flush must not fire.
        for (int i = 0; i < 3; i++) begin
            step(); drive(3'd1, 32'd1, 32'd1, 5'(12 + i));
            mid(); chk("fl_mul_ready", 32'(req_ready), 32'd1);
        end
        step(); flush = 1'b1; drive(3'd1, 32'd2, 32'd2, 5'd15);
        mid(); chk("fl_ready_low", 32'(req_ready), 32'd0);
        step(); flush = 1'b0; idle();
        mid();
        chk("fl_busy", 32'(busy), 32'd0);
        chk("fl_ready", 32'(req_ready), 32'd1);
        repeat (10) step();

        // Illegal opcode 6: fires with alu_op held 0, writes back illegal with zero data.
        step(); drive(3'd6, 32'd5, 32'd5, 5'd9);
        mid(); chk("ill_ready", 32'(req_ready), 32'd1);
        t = cyc; push(t + 4, 5'd9, 32'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step(); if (i == 1) idle();
            mid(); chk("ill_alu_op", 32'(alu_op), 32'd0);
        end
        repeat (2) step();

        // Divide/mod by zero.
`ifdef CALU_DIVZERO_TRAP_EN
        exp_div0 = 32'hFFFF_FFFF; exp_mod0 = 32'd25; exp_dz = 1'b1;
`else
        exp_div0 = 32'h0000_1234; exp_mod0 = 32'h0000_1234; exp_dz = 1'b0;
`endif
        step(); drive(3'd2, 32'd25, 32'd0, 5'd20);
        mid(); chk("dz_div_ready", 32'(req_ready), 32'd1);
        t = cyc; push(t + 14, 5'd20, exp_div0, 1'b0, exp_dz);
        step(); drive(3'd3, 32'd25, 32'd0, 5'd21);
        mid(); chk("dz_mod_ready", 32'(req_ready), 32'd1);
        push(t + 15, 5'd21, exp_mod0, 1'b0, exp_dz);
        step(); idle();
        repeat (16) step();

        // Reset mid-flight discards everything.
        step(); drive(3'd1, 32'd2, 32'd3, 5'd7);
        mid(); chk("rmf_ready", 32'(req_ready), 32'd1);
        step(); idle();
        step(); reset = 1'b1;
        mid(); chk("rmf_ready_rst", 32'(req_ready), 32'd0);
        step(); reset = 1'b0;
        mid();
        chk("rmf_busy", 32'(busy), 32'd0);
        chk("rmf_wb_valid", 32'(wb_valid), 32'd0);
        chk("rmf_wb_data", wb_data, 32'd0);
        chk("rmf_wb_tag", 32'(wb_tag), 32'd0);
        chk("rmf_wb_illegal", 32'(wb_illegal), 32'd0);
        chk("rmf_wb_divz", 32'(wb_divz), 32'd0);
        chk("rmf_alu_op", 32'(alu_op), 32'd0);
        chk("rmf_alu_srcA", alu_srcA, 32'd0);
        repeat (10) step();

        mid();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/complex_alu_ctrl.md
# complex_alu_ctrl

Issue/writeback controller for the multi-cycle complex ALU (mult, div, mod, shl, shr) in the execute stage. It accepts operations from issue with a valid/ready handshake and drives the ALU's operand, opcode and result-select inputs. It tracks each in-flight operation through that operation's fixed megafunction latency, and delivers tagged results to writeback in the order they complete. It reserves writeback slots at issue, so two operations never complete in the same cycle.

## Interface
Parameters:
- TAG_W, 5: destination tag width.
- MUL_LAT, 5: int_mult latency, cycles.
- DIV_LAT, 12: int_div latency; applies to div and mod.
- SHF_LAT, 2: int_shl/int_shr latency.
- All latencies must be in 1..14.

Ports:
- clock  in  1  single clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  issue offers an operation.
- req_ready  out  1  controller accepts the operation this cycle.
- req_op  in  3  opcode: 1 mul, 2 div, 3 mod, 4 shl, 5 shr; 0/6/7 illegal.
- req_srcA, req_srcB  in  32  operands.
- req_tag  in  TAG_W  destination tag.
- flush  in  1  discard all in-flight operations.
- alu_srcA, alu_srcB  out  32  registered operands to the ALU.
- alu_op  out  3  registered opcode to the ALU; 0 when idle.
- alu_select  out  3  combinational result select to the ALU.
- alu_result  in  32  ALU result.
- wb_valid  out  1  result valid this cycle.
- wb_data  out  32  result.
- wb_tag  out  TAG_W  tag of the result.
- wb_illegal  out  1  the result belongs to an illegal opcode.
- wb_divz  out  1  divide/mod by zero (CALU_DIVZERO_TRAP_EN only).
- busy  out  1  at least one operation is in flight.

## Operation
- Effective latency of an operation: L(op) = MUL_LAT, DIV_LAT or SHF_LAT by opcode. Illegal opcodes use SHF_LAT.
- Reservation vector res[1..15], each entry holding {valid, op, tag}.
- Every cycle the vector shifts down: res[k] <= res[k+1]. res[1] retires.
- Accept condition (fire) = req_valid && req_ready.
  - req_ready = !reset && !flush && !res[L(req_op)+1].valid, where the check uses the value after the shift, i.e. current res[L+2].
  - On fire, res[L+1] <= {1, op, tag}.
  - On fire, alu_srcA, alu_srcB and alu_op register the request. alu_op is registered as 0 for illegal opcodes.
- No fire: alu_op <= 0 and operands <= 0. This keeps the ALU's operand gating idle.
- Retire: when res[1].valid, alu_select = res[1].op. Otherwise alu_select = 0.
  - alu_result is registered into wb_data, with wb_tag, wb_valid=1 and wb_illegal = (op is illegal).
  - Illegal ops give wb_data = 0.
- flush: all res[*].valid <= 0 on the next edge and wb_valid <= 0. An operation already in the output register is still presented that cycle. The ALU's internal pipelines drain, but no result is ever selected.
- Reset: all registers 0, so wb_valid, wb_data, wb_tag, wb_illegal, wb_divz, alu_* and busy are all 0. Reset mid-operation discards everything.
- busy = OR of res[*].valid.
- No writeback backpressure: writeback must sink one result per cycle.

## Timing
- Fire at cycle T: the ALU sees its inputs in T+1 and produces its result in T+1+L. wb_valid is high in T+2+L.
- Completion is out of issue order when latencies differ. wb_tag identifies each result.
- Back-to-back operations of the same type issue every cycle.
- A mixed sequence stalls (req_ready=0) only when the target slot is already taken.
- req_ready is combinational from req_op and the reservation state. It does not depend on req_valid.

## Configuration
- CALU_DIVZERO_TRAP_EN defined:
  - Each slot additionally stores a divz bit = (op is div/mod && srcB==0) and srcA.
  - On retire with divz: wb_divz=1, wb_data = 32'hFFFFFFFF for div and the stored srcA for mod. alu_result is ignored.
- Undefined: no extra slot storage, wb_divz tied to 0, and the raw alu_result is forwarded.

## Test plan
- Single op: mul 7×6, tag 3, fire at T -> wb_valid at T+7 (MUL_LAT=5) with wb_data=42 and wb_tag=3. busy high T+1..T+6.
- Collision: fire a mul at T, then a shl (SHF_LAT=2) attempted at T+3 -> req_ready=0 at T+3, fires at T+4. Results arrive at T+7 and T+8 with tags preserved.
- Out of order: div 100/7 tag 1 at T, then shr 0x80>>3 tag 2 at T+1 -> tag 2 result 0x10 at T+5, tag 1 result 14 at T+14.
- Flush: three mults in flight, flush at T+2 -> no wb_valid afterwards, busy=0 at T+3, req_ready=1 at T+3.
- Illegal op 6, tag 9 -> wb_valid at T+4 with wb_illegal=1, wb_data=0, and alu_op held at 0 throughout.
- With CALU_DIVZERO_TRAP_EN: mod 25 by 0 -> wb_divz=1, wb_data=25. Div 25 by 0 -> wb_data=0xFFFFFFFF. Reset asserted mid-flight -> all outputs 0 the next cycle.
